// File: rtl/ras_stack.sv
// Return address stack for the fetch predictor: circular push/pop/replace of call link targets
// with a checkpoint restore port for the pointer and occupancy.
module ras_stack #(
    parameter int unsigned RAS_ENTRIES      = 8,
    parameter int unsigned RAS_INDEX_WIDTH  = 3,
    parameter int unsigned RAS_COUNT_WIDTH  = 4,
    parameter int unsigned RAS_TARGET_WIDTH = 31,
    parameter logic [31:0] INIT_PC          = 32'h0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       link_valid,
    input  logic [31:0]                link_pc,
    input  logic                       ret_valid,
    output logic [31:0]                ret_pc,
    output logic [RAS_INDEX_WIDTH-1:0] ras_index,
    output logic [RAS_COUNT_WIDTH-1:0] ras_count,
    output logic                       ras_empty,
    input  logic                       update_valid,
    input  logic [RAS_INDEX_WIDTH-1:0] update_ras_index,
    input  logic [RAS_COUNT_WIDTH-1:0] update_ras_count
);

    localparam logic [RAS_COUNT_WIDTH-1:0] FullCount = RAS_COUNT_WIDTH'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH-1:0] LastIndex = RAS_INDEX_WIDTH'(RAS_ENTRIES - 1);

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_TARGET_WIDTH-1:0] stack_d [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  ptr_q, ptr_d;
    logic [RAS_COUNT_WIDTH-1:0]  count_q, count_d;

    logic [RAS_INDEX_WIDTH-1:0]  ptr_inc, ptr_dec, wr_idx;
    logic                        wr_en;
    logic [RAS_COUNT_WIDTH-1:0]  restore_count;

    // Bit 0 of a return address is never stored.
    logic unused_link_lsb;
    assign unused_link_lsb = link_pc[0];

    assign ptr_inc       = ptr_q + RAS_INDEX_WIDTH'(1);
    assign ptr_dec       = ptr_q - RAS_INDEX_WIDTH'(1);
    assign restore_count = (update_ras_count > FullCount) ? FullCount : update_ras_count;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        stack_d = stack_q;
        if (update_valid) begin
            ptr_d   = update_ras_index;
            count_d = restore_count;
        end else if (link_valid && ret_valid) begin
            // Return immediately followed by a call: overwrite the top in place.
            wr_en   = 1'b1;
            count_d = (count_q == '0) ? RAS_COUNT_WIDTH'(1) : count_q;
        end else if (link_valid) begin
            wr_en   = 1'b1;
            wr_idx  = ptr_inc;
            ptr_d   = ptr_inc;
            count_d = (count_q == FullCount) ? count_q : count_q + RAS_COUNT_WIDTH'(1);
        end else if (ret_valid) begin
            // Pointer moves even when empty so it stays aligned with checkpoints.
            ptr_d   = ptr_dec;
            count_d = (count_q == '0) ? count_q : count_q - RAS_COUNT_WIDTH'(1);
        end
        if (wr_en) begin
            stack_d[wr_idx] = link_pc[RAS_TARGET_WIDTH:1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q   <= LastIndex;
            count_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack_q[i] <= RAS_TARGET_WIDTH'(INIT_PC[31:1]);
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            stack_q <= stack_d;
        end
    end

    assign ret_pc    = 32'({stack_q[ptr_q], 1'b0});
    assign ras_index = ptr_q;
    assign ras_count = count_q;
    assign ras_empty = (count_q == '0);

endmodule
